// File: rtl/seg_scan6_if.sv
// Display-side bundle for the six-digit multiplexed 7-segment scanner:
// enable, BCD digit inputs and blink request in; digit select, segments and dp out.
interface seg_scan6_if;
  logic       en;
  logic [3:0] sec_1;
  logic [3:0] sec_2;
  logic [3:0] min_1;
  logic [3:0] min_2;
  logic [3:0] hour_1;
  logic [3:0] hour_2;
  logic [5:0] blink_mask;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output en, sec_1, sec_2, min_1, min_2, hour_1, hour_2, blink_mask,
    input  an, seg, dp
  );

  modport slave (
    input  en, sec_1, sec_2, min_1, min_2, hour_1, hour_2, blink_mask,
    output an, seg, dp
  );
endinterface

// File: rtl/seg_scan6.sv
// Six-digit multiplexed 7-segment scanner (hh.mm.ss) with frame-synchronous
// digit snapshot, per-digit blinking and optional hour leading-zero blanking.
module seg_scan6 #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 83,
  parameter int LZ_BLANK     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_scan6_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [FRM_W-1:0]     frm_q, frm_d;
  logic                 phase_q, phase_d;
  logic [5:0][3:0]      snap_q, snap_d;
  logic [5:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;

  logic [5:0][3:0]      digits;
  logic                 tick;
  logic                 frame_end;
  logic                 blank;
  logic [3:0]           cur_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  assign digits = {bus.hour_2, bus.hour_1, bus.min_2, bus.min_1, bus.sec_2, bus.sec_1};

  always_comb begin
    div_cnt_d = div_cnt_q;
    idx_d     = idx_q;
    frm_d     = frm_q;
    phase_d   = phase_q;
    snap_d    = snap_q;
    tick      = bus.en && (div_cnt_q == DIV_LAST);
    frame_end = tick && (idx_q == 3'd5);

    if (!bus.en) begin
      // Disabled: park the scan and keep the snapshot tracking the live digits.
      div_cnt_d = '0;
      idx_d     = '0;
      snap_d    = digits;
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      if (tick) begin
        idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
      if (frame_end) begin
        snap_d = digits;
        if (frm_q == FRM_LAST) begin
          frm_d   = '0;
          phase_d = ~phase_q;
        end else begin
          frm_d = frm_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cur_digit = snap_q[idx_q];
    blank     = !bus.en
              || (bus.blink_mask[idx_q] && !phase_q)
              || ((LZ_BLANK != 0) && (idx_q == 3'd5) && (snap_q[5] == 4'd0));
    an_d      = 6'b111111;
    seg_d     = 7'b1111111;
    dp_d      = 1'b1;
    if (!blank) begin
      an_d  = ~(6'b000001 << idx_q);
      seg_d = seg_decode(cur_digit);
      dp_d  = !((idx_q == 3'd2) || (idx_q == 3'd4));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      frm_q     <= '0;
      phase_q   <= 1'b1;
      snap_q    <= '0;
      an_q      <= 6'b111111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      frm_q     <= frm_d;
      phase_q   <= phase_d;
      snap_q    <= snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_scan6.sv
// Randomized bench for seg_scan6 against a timeline-based reference model
// (scan position derived from enabled-cycle count, blink phase from frame count).
module tb_seg_scan6;
  localparam int SD = 4;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  int         t_en;
  int         frames;
  logic [3:0] msnap [6];
  logic [5:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  seg_scan6_if bus ();

  seg_scan6 #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZ_BLANK(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, expv);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [3:0] in_dig(input int i);
    case (i)
      0: return bus.sec_1;  1: return bus.sec_2;  2: return bus.min_1;
      3: return bus.min_2;  4: return bus.hour_1;
      default: return bus.hour_2;
    endcase
  endfunction

  task automatic set_dig(input int i, input logic [3:0] v);
    case (i)
      0: bus.sec_1 = v;  1: bus.sec_2 = v;  2: bus.min_1 = v;
      3: bus.min_2 = v;  4: bus.hour_1 = v;
      default: bus.hour_2 = v;
    endcase
  endtask

  task automatic model_reset();
    t_en   = 0;
    frames = 0;
    for (int i = 0; i < 6; i++) msnap[i] = 4'd0;
  endtask

  // Expected registered outputs for this edge, then advance the timeline.
  task automatic model_edge();
    int  idx;
    bit  visible;
    bit  blank;
    if (!bus.en) begin
      exp_an = 6'b111111; exp_seg = 7'b1111111; exp_dp = 1'b1;
      t_en = 0;
      for (int i = 0; i < 6; i++) msnap[i] = in_dig(i);
    end else begin
      idx     = (t_en / SD) % 6;
      visible = ((frames / BF) % 2) == 0;
      blank   = (bus.blink_mask[idx] && !visible) || (idx == 5 && msnap[5] == 4'd0);
      if (blank) begin
        exp_an = 6'b111111; exp_seg = 7'b1111111; exp_dp = 1'b1;
      end else begin
        exp_an  = 6'b111111;
        exp_an[idx] = 1'b0;
        exp_seg = seg_of(msnap[idx]);
        exp_dp  = !(idx == 2 || idx == 4);
      end
      t_en++;
      if (t_en % (6 * SD) == 0) begin
        frames++;
        for (int i = 0; i < 6; i++) msnap[i] = in_dig(i);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("an", 32'(bus.an), 32'(exp_an));
    check_val("seg", 32'(bus.seg), 32'(exp_seg));
    check_val("dp", 32'(bus.dp), 32'(exp_dp));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_an", 32'(bus.an), 32'h3f);
    check_val("rst_seg", 32'(bus.seg), 32'h7f);
    check_val("rst_dp", 32'(bus.dp), 32'h1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_val("rst_hold_an", 32'(bus.an), 32'h3f);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.en = 1'b0;
    bus.blink_mask = 6'b0;
    set_dig(0, 4'd1); set_dig(1, 4'd2); set_dig(2, 4'd3);
    set_dig(3, 4'd4); set_dig(4, 4'd5); set_dig(5, 4'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("por_an", 32'(bus.an), 32'h3f);
    check_val("por_seg", 32'(bus.seg), 32'h7f);
    check_val("por_dp", 32'(bus.dp), 32'h1);
    rst_n = 1'b1;
    run(2);

    // Digits 1,2,3,4,5,0: first visible slot one clock after enable.
    bus.en = 1'b1;
    cycle();
    check_val("first_an", 32'(bus.an), 32'h3e);
    check_val("first_seg", 32'(bus.seg), 32'h79);
    run(6 * SD * 2 - 1);

    // Mid-frame change must wait for the frame boundary.
    run(SD + 1);
    set_dig(2, 4'd7);
    run(6 * SD * 2);

    set_dig(0, 4'hC);
    set_dig(5, 4'd1);
    run(6 * SD * 2);

    bus.blink_mask = 6'b000100;
    run(6 * SD * 6);
    bus.blink_mask = 6'b0;

    // Drop enable at slot 3, hold low, resume.
    while (((t_en / SD) % 6) != 3) cycle();
    run(2);
    bus.en = 1'b0;
    set_dig(3, 4'd9);
    run(10);
    bus.en = 1'b1;
    run(6 * SD * 2);

    run(SD + 2);
    async_reset();
    bus.blink_mask = 6'b100001;
    run(6 * SD * 5);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0)
        set_dig($urandom_range(0, 5), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 15) == 0) set_dig(5, 4'd0);
      if ($urandom_range(0, 49) == 0) bus.blink_mask = 6'($urandom);
      if (bus.en) begin
        if ($urandom_range(0, 99) == 0) bus.en = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        bus.en = 1'b1;
      end
      if ($urandom_range(0, 699) == 0) async_reset();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_scan6.md
SEG_SCAN6 -- requirements
Module: seg_scan6

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit slot (min 2).
REQ-002 SHALL have parameter BLINK_FRAMES, default 83, full scan frames per blink-phase toggle (min 1).
REQ-003 SHALL have parameter LZ_BLANK, default 1, blanks hour tens digit when it is 0.
REQ-004 clk  input  1  single system clock, all state on posedge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  display enable; 0 = blank and hold scan at digit 0.
REQ-007 sec_1, sec_2, min_1, min_2, hour_1, hour_2  input  4 each  BCD digits (ones, tens) from the time counters.
REQ-008 blink_mask  input  6  per-digit blink request, bit i = digit index i.
REQ-009 an  output  6  digit select, active-low, an[i] drives digit index i.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.

Function
REQ-012 Digit index order SHALL be 0=sec_1, 1=sec_2, 2=min_1, 3=min_2, 4=hour_1, 5=hour_2.
REQ-013 Divider div_cnt SHALL count 0..SCAN_DIV-1 while en=1; slot tick = div_cnt at SCAN_DIV-1, then div_cnt wraps to 0.
REQ-014 On slot tick, idx SHALL advance by 1, wrapping 5->0.
REQ-015 On slot tick with idx=5 (frame end), all six digit inputs SHALL be snapshotted into frame registers; displayed values change only at frame boundaries (no tearing).
REQ-016 While en=0: div_cnt=0, idx=0, frame counter holds, snapshot loads every cycle, an=6'b111111, seg=7'b1111111, dp=1.
REQ-017 Outputs SHALL be registered: an/seg/dp reflect the current idx and snapshot with exactly 1 clk latency after idx changes.
REQ-018 Scanning: an = all ones except bit idx = 0.
REQ-019 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; values 10-15 SHALL show dash 0111111.
REQ-020 dp SHALL be 0 when idx=2 or idx=4 (hh.mm.ss separators), else 1; dp is subject to blanking rules below.
REQ-021 Frame counter SHALL count frame ends 0..BLINK_FRAMES-1; at terminal count it wraps and blink phase toggles.
REQ-022 Digit i with blink_mask[i]=1 and blink phase=0 SHALL be blanked: an[i]=1, seg=1111111, dp=1 for that slot; blink_mask is sampled live, not snapshotted.
REQ-023 With LZ_BLANK=1 and snapshot hour_2=0, slot 5 SHALL be blanked as in REQ-022; invalid hour_2 still shows dash.
REQ-024 en falling mid-slot SHALL blank outputs on the next clk and restart at idx 0, div_cnt 0 when en returns.
REQ-025 Blink phase and frame counter SHALL not change while en=0.

Reset
REQ-026 rst_n=0 SHALL immediately force div_cnt=0, idx=0, frame counter=0, blink phase=1 (visible), snapshot all 0, an=6'b111111, seg=7'b1111111, dp=1.
REQ-027 After rst_n release with en=1, first visible output (an=111110) SHALL appear 1 clk after the first active edge.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; no snapshot update occurs.

Verification (SCAN_DIV=4, BLINK_FRAMES=2, LZ_BLANK=1)
REQ-029 Digits 1,2,3,4,5,0 (sec_1..hour_2), en=1 after reset -> an cycles 111110,111101,...,011111 every 4 clk; seg 1111001,0100100,0110000,0011001,0010010, then slot 5 blanked (an=111111); dp=0 only at idx 2 and 4.
REQ-030 Change min_1 from 3 to 7 mid-frame -> seg for idx 2 stays 0110000 until after the next idx5->0 tick, then 1111000.
REQ-031 sec_1=4'hC -> idx 0 shows 0111111.
REQ-032 blink_mask=6'b000100 -> idx 2 shown for 2 frames, blanked (an=111111, dp=1) for 2 frames, repeating; other digits unaffected.
REQ-033 en dropped at idx 3, held low 10 clk, raised -> outputs blank 1 clk after drop; scan resumes at idx 0 with a fresh snapshot.
REQ-034 rst_n pulsed low asynchronously mid-slot -> outputs all ones without waiting for clk; blink phase=1 afterwards.
